rx_reset_sequencer: RTL and testbench

- Central arbiter and sequencer for all receiver-reset requests: DC-bias monitor, signal-length check, equalizer monitor, phase-offset monitor and external/software.
- Picks one request by fixed priority and records its cause.
- Drives a registered receiver reset for a programmable hold time, then a hold-off window in which new requests are ignored. This stops reset storms while the front end resynchronises.
- Sits between the watchdog monitors and the rx core reset input. Its per-cause event counters are exposed for register readback.

---
 rtl/rx_reset_sequencer.sv | 156 +++++++++++++++
 tb/tb_rx_reset_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_reset_sequencer.sv
// Fixed-priority arbiter and sequencer for receiver resets: registered reset pulse, then a blanking window.
// Optional per-cause saturating event counters are built only when OPENOFDM_RX_RST_SEQ_CNT_EN is defined.
module rx_reset_sequencer #(
  parameter int NUM_SRC   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         enable,
  input  logic [NUM_SRC-1:0]           req,
  input  logic [7:0]                   hold_cycles,
  input  logic [15:0]                  holdoff_cycles,
  input  logic                         cnt_clear,
  output logic                         receiver_rst,
  output logic                         busy,
  output logic [NUM_SRC-1:0]           rst_cause,
  output logic [NUM_SRC*CNT_WIDTH-1:0] cause_count_flat
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESET   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          timer_q, timer_d;
  logic                 rst_q, rst_d;
  logic                 busy_q, busy_d;
  logic [NUM_SRC-1:0]   cause_q, cause_d;
  logic [NUM_SRC-1:0]   grant;
  logic                 accept;
  logic                 found;

  // Lowest set index wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      rst_q   <= 1'b0;
      busy_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rst_d   = rst_q;
    busy_d  = busy_q;
    cause_d = cause_q;
    accept  = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      timer_d = '0;
      rst_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rst_d  = 1'b0;
          busy_d = 1'b0;
          if (|req) begin
            accept  = 1'b1;
            state_d = S_RESET;
            rst_d   = 1'b1;
            busy_d  = 1'b1;
            cause_d = grant;
            // A zero hold still produces a single reset cycle.
            timer_d = (hold_cycles == 8'd0) ? 16'd0 : ({8'd0, hold_cycles} - 16'd1);
          end
        end
        S_RESET: begin
          if (timer_q == 16'd0) begin
            rst_d = 1'b0;
            if (holdoff_cycles == 16'd0) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              timer_d = '0;
            end else begin
              state_d = S_HOLDOFF;
              busy_d  = 1'b1;
              timer_d = holdoff_cycles - 16'd1;
            end
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        S_HOLDOFF: begin
          rst_d = 1'b0;
          if (timer_q == 16'd0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
          rst_d   = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign receiver_rst = rst_q;
  assign busy         = busy_q;
  assign rst_cause    = cause_q;

`ifdef OPENOFDM_RX_RST_SEQ_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_SRC];

  // Clear has priority over a coincident increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cnt_clear) begin
          cnt_q[i] <= '0;
        end else if (accept && grant[i] && (cnt_q[i] != {CNT_WIDTH{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt_out
    assign cause_count_flat[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
`else
  logic unused_cnt;
  assign unused_cnt       = cnt_clear | accept;
  assign cause_count_flat = '0;
`endif

endmodule

// File: tb/tb_rx_reset_sequencer.sv
// Directed and random stimulus against a remaining-cycles reference model of the reset sequencer.
module tb_rx_reset_sequencer;
  localparam int NS = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           enable = 1'b0;
  logic [NS-1:0]  req = '0;
  logic [7:0]     hold_cycles = 8'd0;
  logic [15:0]    holdoff_cycles = 16'd0;
  logic           cnt_clear = 1'b0;
  logic           receiver_rst;
  logic           busy;
  logic [NS-1:0]  rst_cause;
  logic [NS*CW-1:0] cause_count_flat;

  rx_reset_sequencer #(.NUM_SRC(NS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .req(req),
    .hold_cycles(hold_cycles), .holdoff_cycles(holdoff_cycles), .cnt_clear(cnt_clear),
    .receiver_rst(receiver_rst), .busy(busy), .rst_cause(rst_cause),
    .cause_count_flat(cause_count_flat)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: cycles of reset still to come, cycles of blanking still to come.
  int          rst_left = 0;
  int          blank_left = 0;
  logic [NS-1:0] m_cause = '0;
  int          m_cnt [NS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int k;
    bit acc;
    acc = 0;
    k = 0;
    if (!rstn) begin
      rst_left = 0; blank_left = 0; m_cause = '0;
      for (int i = 0; i < NS; i++) m_cnt[i] = 0;
    end else begin
      if (!enable) begin
        rst_left = 0; blank_left = 0;
      end else if (rst_left > 0) begin
        if (rst_left == 1) blank_left = int'(holdoff_cycles);
        rst_left--;
      end else if (blank_left > 0) begin
        blank_left--;
      end else if (req != '0) begin
        for (int i = NS - 1; i >= 0; i--) if (req[i]) k = i;
        acc = 1;
        rst_left = (hold_cycles == 8'd0) ? 1 : int'(hold_cycles);
        m_cause = NS'(1) << k;
      end
      if (cnt_clear) begin
        for (int i = 0; i < NS; i++) m_cnt[i] = 0;
      end else if (acc && m_cnt[k] < CMAX) begin
        m_cnt[k]++;
      end
    end
  endtask

  function automatic logic [NS*CW-1:0] exp_flat();
    logic [NS*CW-1:0] f;
    f = '0;
`ifdef OPENOFDM_RX_RST_SEQ_CNT_EN
    for (int i = 0; i < NS; i++) f[i*CW +: CW] = CW'(m_cnt[i]);
`endif
    return f;
  endfunction

  // One clock: advance the model with the inputs the DUT sampled, then compare just after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("receiver_rst", 64'(receiver_rst), 64'(rst_left > 0));
    chk("busy", 64'(busy), 64'((rst_left > 0) || (blank_left > 0)));
    chk("rst_cause", 64'(rst_cause), 64'(m_cause));
    chk("cause_count_flat", 64'(cause_count_flat), 64'(exp_flat()));
  endtask

  int rst_hi, busy_hi, rise_n, prev_rst;
  int rises [4];
  logic [CW-1:0] sat_exp;

  initial begin
    for (int i = 0; i < NS; i++) m_cnt[i] = 0;
    // Reset state
    rstn = 1'b0;
    repeat (3) tick();
    chk("reset_rst", 64'(receiver_rst), 64'd0);
    chk("reset_cause", 64'(rst_cause), 64'd0);
    rstn = 1'b1;
    enable = 1'b1;
    tick();

    // Single pulse: 3 reset cycles, 8 busy cycles
    hold_cycles = 8'd3; holdoff_cycles = 16'd5; req = 4'b0100;
    rst_hi = 0; busy_hi = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      req = '0;
      rst_hi += int'(receiver_rst);
      busy_hi += int'(busy);
    end
    chk("pulse_rst_cycles", 64'(rst_hi), 64'd3);
    chk("pulse_busy_cycles", 64'(busy_hi), 64'd8);
    chk("pulse_cause", 64'(rst_cause), 64'(4'b0100));

    // Simultaneous requests: lowest index wins
    hold_cycles = 8'd1; holdoff_cycles = 16'd0; req = 4'b1010;
    tick();
    req = '0;
    chk("prio_cause", 64'(rst_cause), 64'(4'b0010));
    repeat (3) tick();

    // Held request: reset repeats every hold + holdoff + 1 cycles (the extra is the IDLE accept cycle)
    hold_cycles = 8'd2; holdoff_cycles = 16'd4; req = 4'b0001;
    rise_n = 0; prev_rst = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (receiver_rst && prev_rst == 0 && rise_n < 4) begin
        rises[rise_n] = c;
        rise_n++;
      end
      prev_rst = int'(receiver_rst);
    end
    chk("period_rises", 64'(rise_n), 64'd4);
    chk("period_len", 64'(rises[2] - rises[1]), 64'd7);
    req = '0;
    repeat (8) tick();

    // Zero hold / zero holdoff: 1-cycle pulses, immediate re-accept; saturate counter 1
    hold_cycles = 8'd0; holdoff_cycles = 16'd0; req = 4'b0010;
    tick();
    chk("zero_hold_rst", 64'(receiver_rst), 64'd1);
    tick();
    chk("zero_hold_idle", 64'(receiver_rst), 64'd0);
    repeat (40) tick();
`ifdef OPENOFDM_RX_RST_SEQ_CNT_EN
    sat_exp = CW'(CMAX);
`else
    sat_exp = '0;
`endif
    chk("saturate", 64'(cause_count_flat[1*CW +: CW]), 64'(sat_exp));
    // Clear coincident with an accept
    while (receiver_rst) tick();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    req = '0;
    chk("clear_wins", 64'(cause_count_flat[1*CW +: CW]), 64'd0);
    chk("clear_rst", 64'(receiver_rst), 64'd1);
    repeat (3) tick();

    // Drop enable on the second reset cycle
    hold_cycles = 8'd10; holdoff_cycles = 16'd3; req = 4'b0001;
    tick();
    req = '0;
    tick();
    enable = 1'b0;
    tick();
    chk("en_drop_rst", 64'(receiver_rst), 64'd0);
    chk("en_drop_busy", 64'(busy), 64'd0);
    chk("en_drop_cause", 64'(rst_cause), 64'(4'b0001));
    req = 4'b1000;
    repeat (3) tick();
    chk("en_low_ignored", 64'(rst_cause), 64'(4'b0001));
    req = '0;
    enable = 1'b1;
    tick();

    // Synchronous reset mid-RESET
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    rstn = 1'b0;
    tick();
    chk("rstn_mid_rst", 64'(receiver_rst), 64'd0);
    rstn = 1'b1;
    tick();

    // Random traffic, including mid-phase hold/holdoff changes
    for (int c = 0; c < 600; c++) begin
      req = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
      enable = ($urandom_range(0, 19) != 0);
      hold_cycles = 8'($urandom_range(0, 5));
      holdoff_cycles = 16'($urandom_range(0, 6));
      cnt_clear = ($urandom_range(0, 39) == 0);
      rstn = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
